// File: rtl/riscv_defines.sv
// Shared core-wide definitions: datapath widths and the memory arbiter's
// state encoding and default fetch-starvation limit.
package riscv_defines;

    localparam int RISCV_ADDR_WIDTH = 32;
    localparam int RISCV_WORD_WIDTH = 32;

    // Consecutive data grants allowed while a fetch request is waiting.
    localparam int MEM_ARB_MAX_DATA_BURST = 4;

    // IDLE arbitrates combinationally; BUSY_x locks the port to one owner
    // until the memory signals ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage : riscv_defines

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch
// and the load/store unit. Data accesses win by default; a burst counter
// forces a fetch grant after MAX_DATA_BURST back-to-back data grants.
// Requests pass through combinationally (zero latency), the grant is held
// until the memory accepts, and mem_ready_i only influences next state.
module mem_arbiter
    import riscv_defines::*;
#(
    parameter int MAX_DATA_BURST = MEM_ARB_MAX_DATA_BURST
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        imem_valid_i,
    output logic                        imem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] imem_wdata_i,
    input  logic [3:0]                  imem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] imem_rdata_o,

    input  logic                        dmem_valid_i,
    output logic                        dmem_ready_o,
    input  logic [RISCV_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic [RISCV_WORD_WIDTH-1:0] dmem_wdata_i,
    input  logic [3:0]                  dmem_we_i,
    output logic [RISCV_WORD_WIDTH-1:0] dmem_rdata_o,

    output logic                        mem_valid_o,
    input  logic                        mem_ready_i,
    output logic [RISCV_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RISCV_WORD_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]                  mem_we_o,
    input  logic [RISCV_WORD_WIDTH-1:0] mem_rdata_i
);

    localparam int                CNT_W     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_DATA_BURST);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    logic owner_i;    // fetch owns the port this cycle
    logic owner_d;    // LSU owns the port this cycle
    logic req_valid;  // owner is presenting a request
    logic xfer_done;  // owner's request accepted by memory this cycle

    // Ownership: fresh arbitration in IDLE, locked owner in BUSY_x.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        owner_i = 1'b0;
        owner_d = 1'b0;
        case (state_q)
            IDLE: begin
                owner_d = dmem_valid_i &&
                          !(imem_valid_i && (burst_cnt_q == BURST_MAX));
                owner_i = !owner_d && imem_valid_i;
            end
            BUSY_I:  owner_i = 1'b1;
            BUSY_D:  owner_d = 1'b1;
            default: ;
        endcase
        // While reset is held the port stays quiet even if requesters are
        // still asserting valid; an in-flight request is simply abandoned.
        if (!rst_n) begin
            owner_i = 1'b0;
            owner_d = 1'b0;
        end
    end

    // Request mux toward memory; unused fields are zero when nothing is granted.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_we_o    = '0;
        req_valid   = 1'b0;
        if (owner_i && imem_valid_i) begin
            req_valid   = 1'b1;
            mem_addr_o  = imem_addr_i;
            mem_wdata_o = imem_wdata_i;
            mem_we_o    = imem_we_i;
        end else if (owner_d && dmem_valid_i) begin
            req_valid   = 1'b1;
            mem_addr_o  = dmem_addr_i;
            mem_wdata_o = dmem_wdata_i;
            mem_we_o    = dmem_we_i;
        end
    end

    assign mem_valid_o  = req_valid;
    assign xfer_done    = req_valid & mem_ready_i;
    assign imem_ready_o = xfer_done & owner_i;
    assign dmem_ready_o = xfer_done & owner_d;

    // Read data is broadcast; only the owner's ready qualifies it.
    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

    // Next state: lock on an unaccepted grant, release on acceptance.
    // An owner that drops valid mid-transaction keeps the lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (owner_i && !mem_ready_i) begin
                    state_d = BUSY_I;
                end else if (owner_d && !mem_ready_i) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (xfer_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch-starvation counter: counts data completions while fetch waits,
    // saturating; any fetch completion or an uncontended data completion clears it.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (xfer_done && owner_d) begin
            if (!imem_valid_i) begin
                burst_cnt_d = '0;
            end else if (burst_cnt_q != BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
        end else if (xfer_done && owner_i) begin
            burst_cnt_d = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares a single memory port between the instruction fetch path and the load/store unit. It sits between `fetch_stage` / `lsu` and the memory, passing the granted requester's valid/ready transaction straight through and holding the grant until the memory accepts. Data accesses win by default, and a burst counter guarantees fetch forward progress.

## Interface
- `MAX_DATA_BURST`, default 4: maximum consecutive data grants while a fetch request waits; legal range 1..15.
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `imem_valid_i`  in  1  fetch request valid
- `imem_ready_o`  out  1  fetch transaction complete this cycle
- `imem_addr_i`  in  RISCV_ADDR_WIDTH  fetch address
- `imem_wdata_i`  in  RISCV_WORD_WIDTH  fetch write data (normally unused)
- `imem_we_i`  in  4  fetch byte write enables
- `imem_rdata_o`  out  RISCV_WORD_WIDTH  read data to fetch
- `dmem_valid_i`, `dmem_ready_o`, `dmem_addr_i`, `dmem_wdata_i`, `dmem_we_i`, `dmem_rdata_o`: same as the imem set, for the LSU
- `mem_valid_o`  out  1  shared port request valid
- `mem_ready_i`  in  1  memory completes the transaction this cycle
- `mem_addr_o`  out  RISCV_ADDR_WIDTH  address of granted requester
- `mem_wdata_o`  out  RISCV_WORD_WIDTH  write data of granted requester
- `mem_we_o`  out  4  byte enables of granted requester
- `mem_rdata_i`  in  RISCV_WORD_WIDTH  memory read data

## Operation
- States: IDLE, BUSY_I, BUSY_D (`arb_state_t`).
- **IDLE arbitration (combinational, same cycle):**
  - Grant D if `dmem_valid_i` and not (`imem_valid_i` and `burst_cnt == MAX_DATA_BURST`).
  - Otherwise grant I if `imem_valid_i`.
  - Otherwise no grant.
- **On a grant:**
  - `mem_valid_o` = 1. Addr, wdata and we are muxed from the winner.
  - If `mem_ready_i` = 1 in the same cycle, the transaction completes and the state stays IDLE.
  - Otherwise the state moves to BUSY_I or BUSY_D.
- **BUSY_x:** the owner is locked and the other requester is ignored. The outputs pass through the owner's signals. On `mem_ready_i` the state returns to IDLE.
- **Ready routing:**
  - `imem_ready_o` = `mem_ready_i` & owner==I.
  - `dmem_ready_o` = `mem_ready_i` & owner==D.
  - `mem_rdata_i` is broadcast to both `*_rdata_o`.
- **Requester rule:** valid, addr, wdata and we are held stable from assertion until ready. The arbiter does not register them.
  - If the owner drops valid while in BUSY (protocol violation), `mem_valid_o` follows it low and the state is held. No recovery is required.
- **burst_cnt:** width $clog2(MAX_DATA_BURST+1).
  - Increments on each completed D transaction while `imem_valid_i` = 1, saturating at MAX_DATA_BURST.
  - Clears on each completed I transaction.
  - Clears when a D transaction completes with `imem_valid_i` = 0.
- **No grant:** `mem_valid_o` = 0, and `mem_addr_o`, `mem_wdata_o`, `mem_we_o` are driven to 0.

## Timing
- **Reset values:**
  - State IDLE, `burst_cnt` = 0.
  - `mem_valid_o`, `imem_ready_o`, `dmem_ready_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `mem_we_o` = 0.
  - `*_rdata_o` follow `mem_rdata_i`.
- Request to memory latency is 0 cycles: a request in IDLE reaches `mem_valid_o` in the same cycle.
- Back-to-back transactions: after a ready cycle, the next grant is issued in the immediately following cycle. There is no dead cycle.
- Simultaneous I and D requests in IDLE: D wins unless `burst_cnt` has saturated, in which case I wins.
- A reset mid-transaction forces IDLE asynchronously and `mem_valid_o` drops immediately. The memory must tolerate an abandoned request.
- No combinational path from `mem_ready_i` to `mem_valid_o` within a cycle. Ready only affects the next state.

## Structure
- Shared package `riscv_defines.sv`:
  - `RISCV_ADDR_WIDTH` and `RISCV_WORD_WIDTH` (32) already live there.
  - Add `arb_state_t` (IDLE/BUSY_I/BUSY_D) and `MEM_ARB_MAX_DATA_BURST` (4).
- Single module, no sub-module. The owner mux and state register are small enough to stay flat.
- Instantiated in `riscv_core` when the core moves to a unified memory.

## Test plan
- **Single fetch:** imem valid, addr 0x100, ready on the 3rd cycle with rdata 0xDEADBEEF.
  - `mem_addr_o` = 0x100 for 3 cycles.
  - `imem_ready_o` pulses once and `imem_rdata_o` = 0xDEADBEEF.
  - `dmem_ready_o` stays 0.
- **Simultaneous requests:** I at 0x200, D at 0x8000 with we=4'b1111 and wdata 0x12345678, single-cycle ready.
  - D is served first, I in the next cycle.
  - `mem_we_o` = 4'hF only in the first cycle.
- **Lock:** D granted with ready delayed 5 cycles and I raised in cycle 2.
  - `mem_addr_o` stays on the D address until ready.
  - I is granted the cycle after.
- **Starvation guard:** D and I held continuously with single-cycle ready and `MAX_DATA_BURST` = 4.
  - Grant sequence D,D,D,D,I,D,D,D,D,I.
- **Async reset mid BUSY_D:** assert `rst_n` = 0 with no clock edge.
  - `mem_valid_o` = 0 immediately.
  - After release, a new I request is granted in the same cycle.
- **Idle:** no valids for 10 cycles.
  - `mem_valid_o` = 0 throughout.
  - `mem_addr_o`, `mem_we_o` = 0.
  - `burst_cnt` unchanged.
